memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Consumer end of the execute-stage output interface. Takes RegWrite/ResultSrc/MemWrite, ALU result, store data, Rd and PC+4 from execute.
- Registers them in an EX/MEM pipeline register and performs the data-memory access.
- Registers the results in a MEM/WB pipeline register for writeback.
- Exports M-stage signals to the hazard/forwarding unit.

Parameters:
- DMEM_DEPTH, 64, number of 32-bit words in data memory (power of two, ≥4)
- DMEM_AW, $clog2(DMEM_DEPTH), local; word-index width, not overridable

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- RegWriteE  in  1  register-write enable from execute
- ResultSrcE  in  1  0 = ALU result, 1 = memory read data
- MemWriteE  in  1  store enable from execute
- ALUResultE  in  32  effective address / ALU result
- WriteDataE  in  32  store data
- RdE  in  5  destination register
- PCPlus4E  in  32  PC+4 of the instruction
- StallM  in  1  hold EX/MEM contents
- FlushM  in  1  load bubble into EX/MEM
- RegWriteM  out  1  EX/MEM RegWrite, to hazard unit
- RdM  out  5  EX/MEM Rd, to hazard unit
- ALUResultM  out  32  EX/MEM ALU result, forwarding source
- ReadyM  out  1  stage able to accept; constant 1 unless the optional feature is compiled in
- RegWriteW  out  1  MEM/WB RegWrite
- ResultSrcW  out  1  MEM/WB ResultSrc
- ALUResultW  out  32  MEM/WB ALU result
- ReadDataW  out  32  MEM/WB load data
- RdW  out  5  MEM/WB Rd
- PCPlus4W  out  32  MEM/WB PC+4

Behaviour:
- Reset: one clock and synchronous active-high reset (clk, rst). On rst=1 at an edge, every EX/MEM and MEM/WB field clears to 0.
  - Consequently, all M and W outputs are 0 in the cycle after reset.
  - Memory contents are not reset.
- Latency: E inputs are captured at edge N and appear on the M outputs. At edge N+1 the results appear on the W outputs. Total latency is 2 cycles.
- Address: word index = ALUResultM[DMEM_AW+1:2].
  - Bits [1:0] are ignored (misaligned accesses are silently aligned).
  - Upper bits are ignored, so addresses wrap modulo DMEM_DEPTH×4.
- Read: combinational from the EX/MEM address. Captured into ReadDataW every non-bubble advance.
- Write: mem[idx] ← WriteDataM at the edge ending the M cycle when MemWriteM=1, StallM=0 and rst=0.
- Same-address read and write in one M cycle: ReadDataW gets the old word.
- Priority at EX/MEM: rst > FlushM > StallM > load.
  - FlushM: all EX/MEM fields ← 0.
  - StallM: EX/MEM holds its value; MEM/WB loads a bubble (all fields 0), so writeback is not duplicated; the memory write is suppressed.
- A store under stall writes exactly once, on the cycle it advances.
- rst asserted mid-stall or mid-store: the pending store is dropped; EX/MEM is cleared.
- No combinational path from any E input to any output.

Optional Feature:
- Macro: DMEM_CLEAR_ON_RESET_EN.
- When defined, a 2-state FSM controls memory clearing:
  - CLEAR: entered on rst and held during rst. After rst deasserts, it writes 0 to mem[cnt] each cycle, cnt counting 0..DMEM_DEPTH-1. ReadyM=0; EX/MEM and MEM/WB load bubbles; E inputs are ignored.
  - RUN: entered after the write to DEPTH-1. ReadyM=1.
  - Clear takes exactly DMEM_DEPTH cycles after rst falls.
  - rst re-asserted mid-clear restarts cnt at 0.
- When undefined: no FSM, no counter, ReadyM tied to 1, memory contents undefined at power-up.

Decomposition:
- Shared package holds:
  - XLEN=32 and REGADDR_W=5
  - the bubble constant (all-zero control + data)
  - the ResultSrc encodings RESULT_ALU=0 and RESULT_MEM=1
- One sub-module, data_memory (DMEM_DEPTH parameter). It has:
  - combinational read port
  - synchronous write port
  - the optional clear-write mux
- Pipeline registers and the clear FSM stay in memory_stage.

Test Plan:
- Reset: rst=1 for 2 cycles with random E inputs → all M/W outputs 0; ReadyM=1 (macro undefined).
- Store then load: store 0xDEADBEEF to address 0x10. Next cycle, load from 0x10 with ResultSrcE=1, RdE=5, RegWriteE=1 → two cycles later ReadDataW=0xDEADBEEF, RdW=5, RegWriteW=1.
- Same-address write/read: mem[4]=0x11111111. A store of 0x22222222 to 0x10 sits in M → ReadDataW for that beat is 0x11111111; a subsequent load returns 0x22222222.
- Stall/flush:
  - A store to 0x20 is held by StallM for 3 cycles → exactly one write; RegWriteW=0 for those 3 cycles.
  - FlushM=1 together with StallM=1 → EX/MEM becomes a bubble, RegWriteM=0.
- Wrap/misalign: DMEM_DEPTH=64, store 0xA5A5A5A5 to 0x103 → a load from 0x000 returns 0xA5A5A5A5.
- DMEM_CLEAR_ON_RESET_EN defined, DEPTH=64:
  - ReadyM=0 for 64 cycles after rst falls, then 1; a load from any address then returns 0.
  - rst pulsed at cycle 30 → the clear restarts and takes 64 more cycles.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared types and constants for the memory stage slice.
//   XLEN / REGADDR_W       : datapath and register-address widths
//   RESULT_ALU / RESULT_MEM: ResultSrc encodings carried to writeback
//   STATE_CLEAR / STATE_RUN: memory-clear FSM encodings (used only when
//                            DMEM_CLEAR_ON_RESET_EN is defined; RUN otherwise)
//   ex_mem_t / mem_wb_t    : pipeline register layouts and their bubbles
package memory_stage_pkg;

  localparam int XLEN      = 32;
  localparam int REGADDR_W = 5;

  localparam logic RESULT_ALU = 1'b0;
  localparam logic RESULT_MEM = 1'b1;

  localparam logic [0:0] STATE_CLEAR = 1'b0;
  localparam logic [0:0] STATE_RUN   = 1'b1;

  typedef struct packed {
    logic                 reg_write;
    logic                 result_src;
    logic                 mem_write;
    logic [XLEN-1:0]      alu_result;
    logic [XLEN-1:0]      write_data;
    logic [REGADDR_W-1:0] rd;
    logic [XLEN-1:0]      pc_plus4;
  } ex_mem_t;

  typedef struct packed {
    logic                 reg_write;
    logic                 result_src;
    logic [XLEN-1:0]      alu_result;
    logic [XLEN-1:0]      read_data;
    logic [REGADDR_W-1:0] rd;
    logic [XLEN-1:0]      pc_plus4;
  } mem_wb_t;

  // A bubble is all-zero control and data: no register write, no store.
  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: bundle of execute-stage inputs, hazard controls and
// M/W-stage outputs of memory_stage.
//   master : the pipeline around the stage (drives E inputs, StallM, FlushM)
//   slave  : memory_stage itself
//
// Handshake: there is no valid signal; a beat is presented on the E inputs
// every cycle and is taken at the rising edge unless StallM holds EX/MEM or
// ReadyM is 0 (ReadyM=0 means the E beat is discarded, not held).
// state_dbg exposes the clear FSM state (constant STATE_RUN when the clear
// feature is not compiled in).
interface memory_stage_if;
  import memory_stage_pkg::*;

  logic                 RegWriteE;
  logic                 ResultSrcE;
  logic                 MemWriteE;
  logic [XLEN-1:0]      ALUResultE;
  logic [XLEN-1:0]      WriteDataE;
  logic [REGADDR_W-1:0] RdE;
  logic [XLEN-1:0]      PCPlus4E;
  logic                 StallM;
  logic                 FlushM;

  logic                 RegWriteM;
  logic [REGADDR_W-1:0] RdM;
  logic [XLEN-1:0]      ALUResultM;
  logic                 ReadyM;
  logic                 RegWriteW;
  logic                 ResultSrcW;
  logic [XLEN-1:0]      ALUResultW;
  logic [XLEN-1:0]      ReadDataW;
  logic [REGADDR_W-1:0] RdW;
  logic [XLEN-1:0]      PCPlus4W;
  logic [0:0]           state_dbg;

  modport master (
    output RegWriteE, ResultSrcE, MemWriteE, ALUResultE, WriteDataE, RdE,
           PCPlus4E, StallM, FlushM,
    input  RegWriteM, RdM, ALUResultM, ReadyM, RegWriteW, ResultSrcW,
           ALUResultW, ReadDataW, RdW, PCPlus4W, state_dbg
  );

  modport slave (
    input  RegWriteE, ResultSrcE, MemWriteE, ALUResultE, WriteDataE, RdE,
           PCPlus4E, StallM, FlushM,
    output RegWriteM, RdM, ALUResultM, ReadyM, RegWriteW, ResultSrcW,
           ALUResultW, ReadDataW, RdW, PCPlus4W, state_dbg
  );

endinterface

// File: rtl/memory_stage_data_memory.sv
// data_memory: word-addressed data RAM, DMEM_DEPTH x 32 bits.
//   clk       : write clock
//   we/idx/wdata : synchronous write port (word index)
//   rdata     : combinational read of mem[idx]
//   clear_we/clear_idx : (DMEM_CLEAR_ON_RESET_EN only) writes zero to
//               mem[clear_idx]; takes precedence over the normal write
// Contents are never reset by the reset signal.
module data_memory
  import memory_stage_pkg::*;
#(
  parameter int DMEM_DEPTH = 64,
  localparam int DMEM_AW   = $clog2(DMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DMEM_AW-1:0] idx,
  input  logic [XLEN-1:0]    wdata,
`ifdef DMEM_CLEAR_ON_RESET_EN
  input  logic               clear_we,
  input  logic [DMEM_AW-1:0] clear_idx,
`endif
  output logic [XLEN-1:0]    rdata
);

  logic [XLEN-1:0] mem_q [DMEM_DEPTH];

  // Read is combinational, so a same-cycle write to idx is seen only after
  // the edge: the reader gets the old word.
  assign rdata = mem_q[idx];

  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (clear_we) begin
      mem_q[clear_idx] <= '0;
    end else
`endif
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register, data-memory access, MEM/WB register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : memory_stage_if.slave (E inputs, StallM/FlushM, M/W outputs)
// Parameter DMEM_DEPTH: data memory words (power of two, >= 4).
// Optional macro DMEM_CLEAR_ON_RESET_EN: zero the whole memory after reset,
// one word per cycle, with ReadyM low until done.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DMEM_DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  memory_stage_if.slave bus
);

  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  ex_mem_t             exm_d, exm_q;
  mem_wb_t             mwb_d, mwb_q;
  logic [XLEN-1:0]     read_data;
  logic [DMEM_AW-1:0]  mem_idx;
  logic                mem_we;
  logic                run;

`ifdef DMEM_CLEAR_ON_RESET_EN
  logic [0:0]         state_d, state_q;
  logic [DMEM_AW-1:0] cnt_d, cnt_q;
  logic               clear_we;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clear_we = 1'b0;
    if (state_q == STATE_CLEAR) begin
      clear_we = !rst;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == DMEM_AW'(DMEM_DEPTH - 1)) begin
        state_d = STATE_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STATE_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run           = (state_q == STATE_RUN);
  assign bus.state_dbg = state_q;
`else
  assign run           = 1'b1;
  assign bus.state_dbg = STATE_RUN;
`endif

  // EX/MEM next value; rst is applied in the flop block above all of this.
  always_comb begin
    if (!run || bus.FlushM) begin
      exm_d = EX_MEM_BUBBLE;
    end else if (bus.StallM) begin
      exm_d = exm_q;
    end else begin
      exm_d.reg_write  = bus.RegWriteE;
      exm_d.result_src = bus.ResultSrcE;
      exm_d.mem_write  = bus.MemWriteE;
      exm_d.alu_result = bus.ALUResultE;
      exm_d.write_data = bus.WriteDataE;
      exm_d.rd         = bus.RdE;
      exm_d.pc_plus4   = bus.PCPlus4E;
    end
  end

  // While M is stalled its instruction has not left, so W gets a bubble to
  // avoid writing back the same instruction twice.
  always_comb begin
    if (!run || bus.StallM) begin
      mwb_d = MEM_WB_BUBBLE;
    end else begin
      mwb_d.reg_write  = exm_q.reg_write;
      mwb_d.result_src = exm_q.result_src;
      mwb_d.alu_result = exm_q.alu_result;
      mwb_d.read_data  = read_data;
      mwb_d.rd         = exm_q.rd;
      mwb_d.pc_plus4   = exm_q.pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exm_q <= EX_MEM_BUBBLE;
      mwb_q <= MEM_WB_BUBBLE;
    end else begin
      exm_q <= exm_d;
      mwb_q <= mwb_d;
    end
  end

  // Byte offset and bits above the memory size are dropped: misaligned
  // addresses align down and large addresses wrap.
  assign mem_idx = exm_q.alu_result[DMEM_AW+1:2];
  // The store commits only on the edge where it leaves M.
  assign mem_we  = exm_q.mem_write && !bus.StallM && !rst && run;

  data_memory #(.DMEM_DEPTH(DMEM_DEPTH)) u_dmem (
    .clk       (clk),
    .we        (mem_we),
    .idx       (mem_idx),
    .wdata     (exm_q.write_data),
`ifdef DMEM_CLEAR_ON_RESET_EN
    .clear_we  (clear_we),
    .clear_idx (cnt_q),
`endif
    .rdata     (read_data)
  );

  assign bus.RegWriteM  = exm_q.reg_write;
  assign bus.RdM        = exm_q.rd;
  assign bus.ALUResultM = exm_q.alu_result;
  assign bus.ReadyM     = run;
  assign bus.RegWriteW  = mwb_q.reg_write;
  assign bus.ResultSrcW = mwb_q.result_src;
  assign bus.ALUResultW = mwb_q.alu_result;
  assign bus.ReadDataW  = mwb_q.read_data;
  assign bus.RdW        = mwb_q.rd;
  assign bus.PCPlus4W   = mwb_q.pc_plus4;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for memory_stage
// (DMEM_DEPTH = 64). Inputs change 1 ns after a rising edge, outputs are
// checked at that same point, i.e. away from the active edge.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int DEPTH = 64;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  memory_stage_if bus ();

  memory_stage #(.DMEM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic rs, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc);
    bus.RegWriteE  = rw;
    bus.ResultSrcE = rs;
    bus.MemWriteE  = mw;
    bus.ALUResultE = alu;
    bus.WriteDataE = wd;
    bus.RdE        = rd;
    bus.PCPlus4E   = pc;
  endtask

  task automatic idle();
    drive(1'b0, RESULT_ALU, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
    bus.StallM = 1'b0;
    bus.FlushM = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b0, RESULT_ALU, 1'b1, addr, data, 5'd0, 32'h0);
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] rd,
                      input logic [31:0] pc);
    drive(1'b1, RESULT_MEM, 1'b0, addr, 32'h0, rd, pc);
  endtask

  // Bounded wait for ReadyM; an expired bound is a failed comparison.
  task automatic wait_ready();
    for (int i = 0; i < 4 * DEPTH && bus.ReadyM !== 1'b1; i++) tick();
    n_tests++;
    if (bus.ReadyM !== 1'b1) begin
      $display("FAIL wait_ready: ReadyM=%b required 1 within bound", bus.ReadyM);
      n_fail++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.StallM = 1'b0;
    bus.FlushM = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)), $urandom, $urandom,
            5'($urandom_range(31, 0)), $urandom);
      tick();
    end
    n_tests++;
    if ({bus.RegWriteM, bus.RdM, bus.ALUResultM} !== '0) begin
      $display("FAIL reset_m: got %b/%0d/%h required 0", bus.RegWriteM, bus.RdM, bus.ALUResultM);
      n_fail++;
    end
    n_tests++;
    if ({bus.RegWriteW, bus.ResultSrcW, bus.ALUResultW, bus.ReadDataW, bus.RdW, bus.PCPlus4W} !== '0) begin
      $display("FAIL reset_w: got rw=%b rs=%b alu=%h rd_data=%h rd=%0d pc=%h required all 0",
               bus.RegWriteW, bus.ResultSrcW, bus.ALUResultW, bus.ReadDataW, bus.RdW, bus.PCPlus4W);
      n_fail++;
    end
    n_tests++;
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (bus.ReadyM !== 1'b0) begin
      $display("FAIL reset_ready: got %b required 0", bus.ReadyM);
      n_fail++;
    end
`else
    if (bus.ReadyM !== 1'b1) begin
      $display("FAIL reset_ready: got %b required 1", bus.ReadyM);
      n_fail++;
    end
`endif
    rst = 1'b0;
    idle();
    wait_ready();
  endtask

  task automatic test_store_load();
    store(32'h10, 32'hDEADBEEF);
    tick();
    n_tests++;
    if (bus.ALUResultM !== 32'h10 || bus.RegWriteM !== 1'b0) begin
      $display("FAIL sl_m_store: got alu=%h rw=%b required 00000010/0", bus.ALUResultM, bus.RegWriteM);
      n_fail++;
    end
    load(32'h10, 5'd5, 32'h104);
    tick();
    n_tests++;
    if (bus.RdM !== 5'd5 || bus.RegWriteM !== 1'b1) begin
      $display("FAIL sl_m_load: got rd=%0d rw=%b required 5/1", bus.RdM, bus.RegWriteM);
      n_fail++;
    end
    idle();
    tick();
    n_tests++;
    if (bus.ReadDataW !== 32'hDEADBEEF || bus.RdW !== 5'd5 || bus.RegWriteW !== 1'b1) begin
      $display("FAIL sl_w_load: got data=%h rd=%0d rw=%b required deadbeef/5/1", bus.ReadDataW, bus.RdW, bus.RegWriteW);
      n_fail++;
    end
    n_tests++;
    if (bus.ResultSrcW !== RESULT_MEM || bus.PCPlus4W !== 32'h104 || bus.ALUResultW !== 32'h10) begin
      $display("FAIL sl_w_fields: got rs=%b pc=%h alu=%h required 1/00000104/00000010", bus.ResultSrcW, bus.PCPlus4W, bus.ALUResultW);
      n_fail++;
    end
  endtask

  task automatic test_same_addr();
    store(32'h10, 32'h11111111);
    tick();
    store(32'h10, 32'h22222222);
    tick();
    load(32'h10, 5'd7, 32'h200);
    tick();
    n_tests++;
    if (bus.ReadDataW !== 32'h11111111 || bus.RegWriteW !== 1'b0) begin
      $display("FAIL same_addr_old: got data=%h rw=%b required 11111111/0", bus.ReadDataW, bus.RegWriteW);
      n_fail++;
    end
    idle();
    tick();
    n_tests++;
    if (bus.ReadDataW !== 32'h22222222 || bus.RdW !== 5'd7) begin
      $display("FAIL same_addr_new: got data=%h rd=%0d required 22222222/7", bus.ReadDataW, bus.RdW);
      n_fail++;
    end
  endtask

  task automatic test_stall_flush();
    store(32'h20, 32'hAAAA0000);
    tick();
    // Store carrying RegWrite so the stall bubbles on W are observable.
    drive(1'b1, RESULT_ALU, 1'b1, 32'h20, 32'h12345678, 5'd9, 32'h300);
    tick();
    load(32'h20, 5'd10, 32'h304);
    bus.StallM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.RegWriteW !== 1'b0 || bus.RdW !== 5'd0 || bus.RdM !== 5'd9 || bus.ALUResultM !== 32'h20) begin
        $display("FAIL stall_hold_%0d: got rw_w=%b rd_w=%0d rd_m=%0d alu_m=%h required 0/0/9/00000020",
                 i, bus.RegWriteW, bus.RdW, bus.RdM, bus.ALUResultM);
        n_fail++;
      end
    end
    bus.StallM = 1'b0;
    tick();
    // Old word seen here proves no write happened during the stall.
    n_tests++;
    if (bus.RegWriteW !== 1'b1 || bus.RdW !== 5'd9 || bus.ReadDataW !== 32'hAAAA0000) begin
      $display("FAIL stall_release: got rw=%b rd=%0d data=%h required 1/9/aaaa0000", bus.RegWriteW, bus.RdW, bus.ReadDataW);
      n_fail++;
    end
    idle();
    tick();
    n_tests++;
    if (bus.ReadDataW !== 32'h12345678 || bus.RdW !== 5'd10) begin
      $display("FAIL stall_store_once: got data=%h rd=%0d required 12345678/10", bus.ReadDataW, bus.RdW);
      n_fail++;
    end
    load(32'h20, 5'd11, 32'h308);
    tick();
    idle();
    bus.StallM = 1'b1;
    bus.FlushM = 1'b1;
    tick();
    n_tests++;
    if (bus.RegWriteM !== 1'b0 || bus.RdM !== 5'd0 || bus.RegWriteW !== 1'b0) begin
      $display("FAIL flush_over_stall: got rw_m=%b rd_m=%0d rw_w=%b required 0/0/0", bus.RegWriteM, bus.RdM, bus.RegWriteW);
      n_fail++;
    end
    idle();
    load(32'h20, 5'd12, 32'h30C);
    bus.FlushM = 1'b1;
    tick();
    n_tests++;
    if (bus.RegWriteM !== 1'b0 || bus.RdM !== 5'd0) begin
      $display("FAIL flush_only: got rw=%b rd=%0d required 0/0", bus.RegWriteM, bus.RdM);
      n_fail++;
    end
    idle();
    tick();
  endtask

  task automatic test_wrap();
    store(32'h103, 32'hA5A5A5A5);
    tick();
    load(32'h000, 5'd3, 32'h400);
    tick();
    load(32'h002, 5'd4, 32'h404);
    tick();
    n_tests++;
    if (bus.ReadDataW !== 32'hA5A5A5A5 || bus.ALUResultW !== 32'h0 || bus.RdW !== 5'd3) begin
      $display("FAIL wrap_load0: got data=%h alu=%h rd=%0d required a5a5a5a5/0/3", bus.ReadDataW, bus.ALUResultW, bus.RdW);
      n_fail++;
    end
    idle();
    tick();
    n_tests++;
    if (bus.ReadDataW !== 32'hA5A5A5A5 || bus.ALUResultW !== 32'h2) begin
      $display("FAIL misalign_load2: got data=%h alu=%h required a5a5a5a5/2", bus.ReadDataW, bus.ALUResultW);
      n_fail++;
    end
  endtask

  task automatic test_rst_mid_store();
    logic [31:0] exp;
    store(32'h30, 32'h0BADF00D);
    tick();
    store(32'h30, 32'h55555555);
    tick();
    idle();
    bus.StallM = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if (bus.ALUResultM !== 32'h0 || bus.RegWriteW !== 1'b0) begin
      $display("FAIL rst_mid_stall: got alu_m=%h rw_w=%b required 0/0", bus.ALUResultM, bus.RegWriteW);
      n_fail++;
    end
    rst = 1'b0;
    idle();
    wait_ready();
    load(32'h30, 5'd4, 32'h500);
    tick();
    idle();
    tick();
`ifdef DMEM_CLEAR_ON_RESET_EN
    exp = 32'h0;
`else
    exp = 32'h0BADF00D;
`endif
    n_tests++;
    if (bus.ReadDataW !== exp) begin
      $display("FAIL rst_drops_store: got %h required %h", bus.ReadDataW, exp);
      n_fail++;
    end
  endtask

`ifdef DMEM_CLEAR_ON_RESET_EN
  task automatic test_clear();
    int cnt;
    store(32'h44, 32'h77777777);
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (bus.ReadyM !== 1'b0 || bus.state_dbg !== STATE_CLEAR) begin
      $display("FAIL clear_enter: got ready=%b state=%b required 0/0", bus.ReadyM, bus.state_dbg);
      n_fail++;
    end
    cnt = 0;
    while (bus.ReadyM !== 1'b1 && cnt < 4 * DEPTH) begin
      tick();
      cnt++;
    end
    n_tests++;
    if (cnt != DEPTH) begin
      $display("FAIL clear_len: got %0d cycles required %0d", cnt, DEPTH);
      n_fail++;
    end
    load(32'h44, 5'd6, 32'h600);
    tick();
    idle();
    tick();
    n_tests++;
    if (bus.ReadDataW !== 32'h0 || bus.RdW !== 5'd6) begin
      $display("FAIL clear_zero: got data=%h rd=%0d required 0/6", bus.ReadDataW, bus.RdW);
      n_fail++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (bus.ReadyM !== 1'b1 && cnt < 4 * DEPTH) begin
      tick();
      cnt++;
    end
    n_tests++;
    if (cnt != DEPTH) begin
      $display("FAIL clear_restart_len: got %0d cycles required %0d", cnt, DEPTH);
      n_fail++;
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    idle();
    test_reset();
    test_store_load();
    test_same_addr();
    test_stall_flush();
    test_wrap();
    test_rst_mid_store();
`ifdef DMEM_CLEAR_ON_RESET_EN
    test_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
